div_share_arb: RTL and testbench

- Round-robin arbiter/sequencer that shares one 16-bit iterative divider among N requesters.
- Accepts operand bundles (in0, in1, shift) over valid/ready, launches the divider with a one-cycle start pulse, and waits for its done pulse.
- Returns the result to the granted requester with a one-cycle response pulse.
- Sits between lock-loop consumers (gain/normalisation stages) and the single divider instance.

---
 rtl/div_share_arb.sv | 156 +++++++++++++++
 tb/tb_div_share_arb.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arb.sv
// div_share_arb: round-robin sequencer that shares one iterative 16-bit
// divider among N requesters. It accepts an operand bundle, pulses the divider
// start, waits for done and returns a one-cycle response to the owner.
// Optional build macro: DIV_TIMEOUT_EN adds a WAIT-state watchdog that
// answers with rsp_err=1 after TIMEOUT cycles without div_done.
module div_share_arb #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [16*N-1:0]   req_in0,
    input  logic [16*N-1:0]   req_in1,
    input  logic [4*N-1:0]    req_shift,
    output logic [N-1:0]      rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              div_once,
    output logic [15:0]       div_in0,
    output logic [15:0]       div_in1,
    output logic [3:0]        div_shift,
    input  logic              div_done,
    input  logic [15:0]       div_out
);

    localparam int unsigned NU = N;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] last, owner, gnt, cand;
    logic           gnt_any, accept, tmo, fin;
    logic [15:0]    sel_in0, sel_in1;
    logic [3:0]     sel_shift;

    if (N < 2 || N > 8 || (1 << IDW) < N || TIMEOUT < 1) begin : g_cfg_check
        $error("div_share_arb: invalid N/IDW/TIMEOUT combination");
    end

    // round-robin search starting just after the last granted requester
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= NU; k++) begin
            cand = IDW'((32'(last) + k) % NU);
            if (!gnt_any && req_valid[cand]) begin
                gnt     = cand;
                gnt_any = 1'b1;
            end
        end
    end

    // operand mux for the granted requester
    always_comb begin
        sel_in0   = '0;
        sel_in1   = '0;
        sel_shift = '0;
        for (int unsigned k = 0; k < NU; k++) begin
            if (gnt == IDW'(k)) begin
                sel_in0   = req_in0[16*k +: 16];
                sel_in1   = req_in1[16*k +: 16];
                sel_shift = req_shift[4*k +: 4];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (fin) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: grant is only offered while IDLE, start pulse is the ISSUE cycle
    always_comb begin
        req_ready = '0;
        for (int unsigned k = 0; k < NU; k++) begin
            req_ready[k] = (state == IDLE) && gnt_any && (gnt == IDW'(k));
        end
        busy     = (state != IDLE);
        div_once = (state == ISSUE);
    end

    assign accept = |(req_valid & req_ready);
    assign fin    = (state == WAIT) && (div_done || tmo);

    // operand capture, round-robin pointer and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= IDW'(N - 1);
            owner     <= '0;
            div_in0   <= '0;
            div_in1   <= '0;
            div_shift <= '0;
            rsp_valid <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (accept) begin
                div_in0   <= sel_in0;
                div_in1   <= sel_in1;
                div_shift <= sel_shift;
                owner     <= gnt;
                last      <= gnt;
            end
            if (fin) begin
                rsp_valid[owner] <= 1'b1;
                rsp_id           <= owner;
                rsp_data         <= div_done ? div_out : '0;
            end
        end
    end

`ifdef DIV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt;

    // watchdog counts WAIT cycles and restarts on every entry to WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 tmo_cnt <= '0;
        else if (state != WAIT)  tmo_cnt <= '0;
        else                     tmo_cnt <= tmo_cnt + 1'b1;
    end

    // fires on the TIMEOUT-th WAIT cycle; a real done in that cycle wins
    assign tmo = (state == WAIT) && !div_done && (tmo_cnt == CW'(TIMEOUT - 1));

    // error flag travels with the response pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      rsp_err <= 1'b0;
        else if (fin) rsp_err <= !div_done;
    end
`else
    assign tmo     = 1'b0;
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_div_share_arb.sv
// Testbench for div_share_arb: directed steps plus a randomized phase, checked
// against a transaction-level model (round-robin choice, fixed latencies,
// divider function) with a behavioural divider attached to the DUT.
module tb_div_share_arb;

    localparam int N       = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid, req_ready, rsp_valid;
    logic [16*N-1:0]   req_in0, req_in1;
    logic [4*N-1:0]    req_shift;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_data, div_in0, div_in1, div_out;
    logic              rsp_err, busy, div_once, div_done;
    logic [3:0]        div_shift;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] pm = '0;
    logic [15:0]  in0a [N];
    logic [15:0]  in1a [N];
    logic [3:0]   sha  [N];
    int           mlast;
    logic [15:0]  last_data;

    bit           dm_hang  = 1'b0;
    bit           dm_stray = 1'b0;
    logic [3:0]   dm_cnt;
    logic [15:0]  dm_res;

    always #5 clk = ~clk;

    div_share_arb #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in0(req_in0), .req_in1(req_in1), .req_shift(req_shift),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .div_once(div_once),
        .div_in0(div_in0), .div_in1(div_in1), .div_shift(div_shift),
        .div_done(div_done), .div_out(div_out)
    );

    assign req_valid = pm;

    always_comb begin
        req_in0   = '0;
        req_in1   = '0;
        req_shift = '0;
        for (int k = 0; k < N; k++) begin
            req_in0[16*k +: 16] = in0a[k];
            req_in1[16*k +: 16] = in1a[k];
            req_shift[4*k +: 4] = sha[k];
        end
    end

    // divider function: F passes in1, otherwise (in0 << shift) / in1, all-ones on /0
    function automatic logic [15:0] divf(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] s);
        logic [31:0] num;
        if (s == 4'hF) return b;
        if (b == 16'h0) return 16'hFFFF;
        num = {16'h0, a} << s;
        return 16'(num / {16'h0, b});
    endfunction

    function automatic int rr(input logic [N-1:0] m, input int lst);
        for (int k = 1; k <= N; k++)
            if (m[(lst + k) % N]) return (lst + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // behavioural divider: done 1 cycle after start for shift 0/F, 7 otherwise
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_cnt <= '0;
            dm_res <= '0;
        end else if (div_once) begin
            dm_cnt <= (div_shift == 4'h0 || div_shift == 4'hF) ? 4'd1 : 4'd7;
            dm_res <= divf(div_in0, div_in1, div_shift);
        end else if (dm_cnt != 0) begin
            dm_cnt <= dm_cnt - 4'd1;
        end
    end
    assign div_done = (dm_cnt == 4'd1 && !dm_hang) || dm_stray;
    assign div_out  = dm_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic randops(input int k);
        in0a[k] = 16'($urandom);
        in1a[k] = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
        case ($urandom_range(0, 3))
            0:       sha[k] = 4'h0;
            1:       sha[k] = 4'hF;
            default: sha[k] = 4'($urandom_range(1, 14));
        endcase
    endtask

    task automatic newmask();
        logic [N-1:0] m;
        m = N'($urandom_range(1, (1 << N) - 1));
        for (int k = 0; k < N; k++)
            if (m[k] && !pm[k]) randops(k);
        pm = m;
    endtask

    // One transaction. Entered in cycle 0 (after the negedge) with pm nonzero;
    // returns at the negedge of the response cycle.
    // mode 0: requests cleared after accept; 1: all held; 2: random churn.
    task automatic run_txn(input int mode, input bit hang);
        int g, n, explat;
        logic [15:0] expd, e0, e1;
        logic [3:0]  es;
        logic        experr;
        dm_hang = hang;
        #1;
        g = rr(pm, mlast);
        chk("ready_grant", req_ready, onehot(g));
        chk("busy_idle", busy, 0);
        if (g < 0) return;
        e0 = in0a[g]; e1 = in1a[g]; es = sha[g];
        expd   = divf(e0, e1, es);
        explat = (es == 4'h0 || es == 4'hF) ? 3 : 9;
        experr = 1'b0;
        if (hang) begin
            explat = TIMEOUT + 2;
            expd   = 16'h0;
            experr = 1'b1;
        end
        @(posedge clk); #1;
        if (mode == 0) pm = '0;
        else if (mode == 2) begin
            pm[g] = 1'b0;
            newmask();
        end
        @(negedge clk);
        chk("div_once", div_once, 1);
        chk("busy_issue", busy, 1);
        chk("ready_busy", req_ready, 0);
        chk("div_in0", div_in0, e0);
        chk("div_in1", div_in1, e1);
        chk("div_shift", div_shift, es);
        chk("rsp_pulse_end", rsp_valid, 0);
        chk("rsp_hold", rsp_data, last_data);
        n = 1;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (mode == 2 && $urandom_range(0, 3) == 0) newmask();
            @(negedge clk);
            if (rsp_valid !== '0) break;
            chk("busy_wait", busy, 1);
            chk("once_wait", div_once, 0);
        end
        chk("rsp_latency", n, explat);
        chk("rsp_valid", rsp_valid, onehot(g));
        chk("rsp_id", rsp_id, g);
        chk("rsp_data", rsp_data, expd);
        chk("rsp_err", rsp_err, experr);
        chk("busy_rsp", busy, 0);
        mlast     = g;
        last_data = expd;
        dm_hang   = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            in0a[k] = '0; in1a[k] = '0; sha[k] = '0;
        end
        mlast     = N - 1;
        last_data = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_div_once", div_once, 0);
        chk("rst_div_ops", {div_in0, div_in1[11:0], div_shift}, 0);
        chk("rst_ready", req_ready, 0);
        rst = 1'b0;
        @(negedge clk);

        // requester 1, short path
        in0a[1] = 16'h4000; in1a[1] = 16'h0003; sha[1] = 4'h0;
        pm = 4'b0010;
        run_txn(0, 1'b0);

        // requester 2, pass-through mode
        in0a[2] = 16'h5555; in1a[2] = 16'h1234; sha[2] = 4'hF;
        pm = 4'b0100;
        run_txn(0, 1'b0);

        // requester 0, long path
        in0a[0] = 16'h0100; in1a[0] = 16'h0007; sha[0] = 4'h3;
        pm = 4'b0001;
        run_txn(0, 1'b0);

        // stray done while idle produces nothing
        @(posedge clk); #1;
        dm_stray = 1'b1;
        @(posedge clk); #1;
        dm_stray = 1'b0;
        @(negedge clk);
        chk("stray_rsp", rsp_valid, 0);
        chk("stray_busy", busy, 0);

        // reset asserted during WAIT: no response, pointer back to N-1
        in0a[1] = 16'h0ABC; in1a[1] = 16'h0011; sha[1] = 4'h5;
        pm = 4'b0010;
        @(posedge clk); #1;
        pm = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        mlast     = N - 1;
        last_data = '0;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_rsp", rsp_valid, 0);
            chk("post_rst_busy", busy, 0);
        end

        // all requesters held valid: grants rotate 0,1,2,3,0 with overlap
        for (int k = 0; k < N; k++) begin
            in0a[k] = 16'(16'h1000 * (k + 1)); in1a[k] = 16'(k + 2);
            sha[k]  = (k % 2 == 0) ? 4'h0 : 4'h2;
        end
        pm = 4'b1111;
        repeat (5) run_txn(1, 1'b0);

        // randomized traffic with requests appearing and dropping
        repeat (60) run_txn(2, 1'b0);

`ifdef DIV_TIMEOUT_EN
        // divider never answers: watchdog response, then normal service
        run_txn(0, 1'b1);
`endif
        in0a[2] = 16'h8000; in1a[2] = 16'h0010; sha[2] = 4'h0;
        pm = 4'b0100;
        run_txn(0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "time limit");
    end

endmodule
